// File: rtl/swi_conditioner.sv
// Switch input conditioner: per-bit synchroniser, debounce FSM, edge pulses
// and a push-to-toggle flag for the LED sequencer controls.
module swi_conditioner #(
  parameter int NBITS           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TOGGLE_BIT      = 2
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] SWI,
  output logic [NBITS-1:0] swi_level,
  output logic [NBITS-1:0] swi_rise,
  output logic [NBITS-1:0] swi_fall,
  output logic             any_change,
  output logic             toggle_q
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [NBITS-1:0] r_sync [SYNC_STAGES];
  state_t           r_state    [NBITS];
  state_t           w_state_nx [NBITS];
  logic [CW-1:0]    r_cnt      [NBITS];
  logic [CW-1:0]    w_cnt_nx   [NBITS];
  logic [NBITS-1:0] w_sync;
  logic [NBITS-1:0] w_commit;
  logic [NBITS-1:0] r_level;
  logic [NBITS-1:0] r_rise;
  logic [NBITS-1:0] r_fall;
  logic             r_any;
  logic             r_toggle;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchroniser chain; only the last stage is used downstream.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        r_sync[j] <= '0;
      end
    end else begin
      r_sync[0] <= SWI;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        r_sync[j] <= r_sync[j-1];
      end
    end
  end

  // Debounce next-state logic; a commit always means sync differs from level.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_commit   = '0;
    for (int i = 0; i < NBITS; i++) begin
      case (r_state[i])
        STABLE: begin
          if (w_sync[i] != r_level[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              w_commit[i] = 1'b1;
            end else begin
              w_state_nx[i] = PENDING;
              w_cnt_nx[i]   = CW'(1);
            end
          end else begin
            w_cnt_nx[i] = '0;
          end
        end
        PENDING: begin
          if (w_sync[i] == r_level[i]) begin
            w_state_nx[i] = STABLE;
            w_cnt_nx[i]   = '0;
          end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            w_commit[i] = 1'b1;
          end else begin
            w_cnt_nx[i] = r_cnt[i] + CW'(1);
          end
        end
        default: begin
          w_state_nx[i] = STABLE;
          w_cnt_nx[i]   = '0;
        end
      endcase
      if (w_commit[i]) begin
        w_state_nx[i] = STABLE;
        w_cnt_nx[i]   = '0;
      end else begin
        w_commit[i] = 1'b0;
      end
    end
  end

  // FSM state, counters and all registered outputs.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBITS; i++) begin
        r_state[i] <= STABLE;
        r_cnt[i]   <= '0;
      end
      r_level  <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_any    <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_level  <= r_level ^ w_commit;
      r_rise   <= w_commit & w_sync;
      r_fall   <= w_commit & ~w_sync;
      r_any    <= |w_commit;
      r_toggle <= r_toggle ^ (w_commit[TOGGLE_BIT] & w_sync[TOGGLE_BIT]);
    end
  end

  assign swi_level  = r_level;
  assign swi_rise   = r_rise;
  assign swi_fall   = r_fall;
  assign any_change = r_any;
  assign toggle_q   = r_toggle;

endmodule

// File: doc/swi_conditioner.md
Name: swi_conditioner

Overview:
- Input-conditioning stage between the raw board switches and the LED sequencer (pisca-pisca). The sequencer consumes SWI as reset/freeze/direction controls.
- Each switch bit is synchronised into clk_2, then debounced. The block outputs a clean level per bit and one-cycle rise and fall pulses.
- A toggle flag flips on each debounced press of a selected bit, so direction can be changed with a momentary push instead of a held switch.

Parameters:
- NBITS, 8, number of switch bits conditioned.
- SYNC_STAGES, 2, synchroniser flops per bit (>=2).
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a new value must hold before it is committed (>=1).
- TOGGLE_BIT, 2, index of the bit whose debounced rising edge flips toggle_q.

Ports:
- clk_2  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- SWI  input  NBITS  raw, asynchronous, bouncy switch inputs.
- swi_level  output  NBITS  debounced, registered switch level.
- swi_rise  output  NBITS  one-cycle pulse when swi_level[i] goes 0->1.
- swi_fall  output  NBITS  one-cycle pulse when swi_level[i] goes 1->0.
- any_change  output  1  OR of swi_rise and swi_fall, registered.
- toggle_q  output  1  flips on each swi_rise[TOGGLE_BIT].

Behaviour:
- Reset (async assert, sync release by the board):
  - All synchroniser flops, counters, swi_level, swi_rise, swi_fall, any_change and toggle_q are 0.
  - All per-bit FSMs are in STABLE.
- Synchroniser: SYNC_STAGES-deep flop chain per bit. Only the last stage, sync[i], feeds logic.
- Per-bit FSM, with counter cnt[i] of width $clog2(DEBOUNCE_CYCLES)+1:
  - STABLE, sync[i]==swi_level[i]: stay, cnt=0.
  - STABLE, sync[i]!=swi_level[i], DEBOUNCE_CYCLES==1: commit immediately.
  - STABLE, sync[i]!=swi_level[i], otherwise: go to PENDING, cnt=1.
  - PENDING, sync[i]==swi_level[i] (bounce): go to STABLE, cnt=0, no output change.
  - PENDING, sync[i]!=swi_level[i], cnt==DEBOUNCE_CYCLES-1: commit.
  - PENDING, sync[i]!=swi_level[i], otherwise: cnt+1.
  - Commit means: swi_level[i] <= sync[i], go to STABLE, cnt=0.
- Latency: count the first clk_2 edge that samples a new stable raw value as edge 1. swi_level[i] updates at edge SYNC_STAGES+DEBOUNCE_CYCLES, which is edge 6 with defaults.
- Pulses:
  - swi_rise[i] / swi_fall[i] are registered and asserted for exactly the cycle following the commit edge, i.e. concurrent with the new swi_level.
  - Pulses are 0 in every other cycle.
- any_change: registered in the same cycle as the pulses. Equals |(swi_rise|swi_fall), computed from the commit conditions.
- toggle_q: inverts at the same edge at which swi_rise[TOGGLE_BIT] is asserted; otherwise holds.
- Glitches: any synchronised excursion shorter than DEBOUNCE_CYCLES cycles produces no level change and no pulse. The counter restarts from 0 on each return to the committed value.
- Independence: bits are independent. Simultaneous commits on several bits produce simultaneous pulses in the same cycle.
- Reset high at power-up: if SWI bits are already 1 at reset release, they are treated as new values. Commit follows after the normal latency, with a swi_rise pulse and a toggle if the bit is TOGGLE_BIT.
- Reset mid-debounce: discards pending state and all outputs return to 0 immediately (async).
- No combinational path from SWI to any output.

Test Plan:
- Reset, then SWI=8'h00 held 20 cycles -> all outputs 0, no pulses.
- SWI[0] 0->1 clean, held -> swi_level[0]=1 at edge 6. swi_rise[0] and any_change high for one cycle only. swi_fall all 0.
- SWI[1] bounce pattern 1,0,1,1,0,1 then held 1 (per clk_2 sample) -> no commit before the final run. Commit at edge 6 counted from the start of the final stable run; single swi_rise[1].
- SWI[2] pressed and released cleanly 3 times, each level held 10 cycles -> toggle_q goes 1,0,1; three swi_rise[2] and three swi_fall[2] pulses.
- SWI=8'hFF applied in one cycle -> swi_level=8'hFF at edge 6, swi_rise=8'hFF for one cycle, toggle_q=1.
- SWI[3] held 1, reset asserted at edge 4 (mid-debounce) and released 2 cycles later -> outputs 0 during reset. After release, commit 6 edges later with one swi_rise[3].
